// File: rtl/pio_rst_seq.sv
// pio_rst_seq: PIO subsystem reset-handshake sequencer with passive read-drain monitor.
// Define PIO_RST_SEQ_TIMEOUT_EN to bound the DRAIN state by DRAIN_TIMEOUT cycles.
module pio_rst_seq #(
  parameter int OUTSTD_W      = 8,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int RST_HOLD      = 16
) (
  input  logic       Clk_i,
  input  logic       Rstn_i,
  input  logic       pio_subsystem_cold_rst_n,
  input  logic       pio_subsystem_warm_rst_n,
  input  logic       pio_subsystem_rst_req,
  input  logic       pio_initiate_rst_req_rdy,
  output logic       pio_subsystem_cold_rst_ack_n,
  output logic       pio_subsystem_warm_rst_ack_n,
  output logic       pio_subsystem_rst_rdy,
  output logic       pio_initiate_warmrst_req,
  input  logic       mon_read,
  input  logic       mon_waitrequest,
  input  logic       mon_readdatavalid,
  input  logic [3:0] mon_burstcount,
  input  logic       sw_warmrst_req,
  output logic       app_rst_n,
  output logic [2:0] state_o,
  output logic       drain_timeout_o,
  output logic       outstd_ovf_o
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    WREQ  = 3'd1,
    DRAIN = 3'd2,
    RDY   = 3'd3,
    RST   = 3'd4
  } state_t;

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int SUM_W  = OUTSTD_W + 5;
  localparam logic [SUM_W-1:0] OUTSTD_MAX = SUM_W'({OUTSTD_W{1'b1}});

  state_t              state;
  state_t              nxt;
  logic [OUTSTD_W-1:0] outstd;
  logic [HOLD_W-1:0]   hold;
  logic                sw_pend;
  logic                abort;
  logic                enter_rst;
  logic                tmo_hit;
  logic [SUM_W-1:0]    beats_in;
  logic [SUM_W-1:0]    outstd_sum;
  logic [SUM_W-1:0]    outstd_net;

  function automatic logic [OUTSTD_W-1:0] sat_outstd(input logic [SUM_W-1:0] v);
    if (v > OUTSTD_MAX) return '1;
    return v[OUTSTD_W-1:0];
  endfunction

  assign abort     = !pio_subsystem_cold_rst_n || !pio_subsystem_warm_rst_n;
  assign enter_rst = (nxt == RST) && (state != RST);
  assign state_o   = state;

  // Net beat change for this cycle; a valid with nothing outstanding is dropped.
  always_comb begin
    beats_in = '0;
    if (mon_read && !mon_waitrequest)
      beats_in = (mon_burstcount == 4'd0) ? SUM_W'(1) : SUM_W'(mon_burstcount);
    outstd_sum = SUM_W'(outstd) + beats_in;
    outstd_net = outstd_sum;
    if (mon_readdatavalid && (outstd_sum != '0))
      outstd_net = outstd_sum - SUM_W'(1);
  end

`ifdef PIO_RST_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
  logic [TMO_W-1:0] drain_cnt;

  assign tmo_hit = (drain_cnt >= TMO_W'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i)
      drain_cnt <= '0;
    else if ((state == DRAIN) && (nxt == DRAIN))
      drain_cnt <= drain_cnt + TMO_W'(1);
    else
      drain_cnt <= '0;
  end
`else
  logic unused_cfg;
  assign tmo_hit    = 1'b0;
  assign unused_cfg = (DRAIN_TIMEOUT < 1);
`endif

  always_comb begin
    nxt = state;
    case (state)
      RUN: begin
        if (abort)                      nxt = RST;
        else if (pio_subsystem_rst_req) nxt = DRAIN;
        else if (sw_pend)               nxt = WREQ;
      end
      WREQ: begin
        if (abort)                         nxt = RST;
        else if (pio_subsystem_rst_req)    nxt = DRAIN;
        else if (pio_initiate_rst_req_rdy) nxt = RUN;
      end
      DRAIN: begin
        if (abort)                               nxt = RST;
        else if (!pio_subsystem_rst_req)         nxt = RUN;
        else if ((outstd == '0) || tmo_hit)      nxt = RDY;
      end
      RDY: begin
        if (abort)                       nxt = RST;
        else if (!pio_subsystem_rst_req) nxt = RUN;
      end
      RST: begin
        if (!abort && (hold >= HOLD_W'(RST_HOLD)) &&
            pio_subsystem_cold_rst_ack_n && pio_subsystem_warm_rst_ack_n)
          nxt = RUN;
      end
      default: nxt = RST;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i) begin
      state                        <= RST;
      hold                         <= '0;
      outstd                       <= '0;
      sw_pend                      <= 1'b0;
      app_rst_n                    <= 1'b0;
      pio_subsystem_cold_rst_ack_n <= 1'b1;
      pio_subsystem_warm_rst_ack_n <= 1'b1;
      pio_subsystem_rst_rdy        <= 1'b0;
      pio_initiate_warmrst_req     <= 1'b0;
      drain_timeout_o              <= 1'b0;
      outstd_ovf_o                 <= 1'b0;
    end else begin
      state                    <= nxt;
      pio_subsystem_rst_rdy    <= (nxt == RDY) || (nxt == RST);
      pio_initiate_warmrst_req <= (nxt == WREQ);
      app_rst_n                <= (nxt != RST);

      pio_subsystem_cold_rst_ack_n <= (state == RST) ? pio_subsystem_cold_rst_n : 1'b1;
      pio_subsystem_warm_rst_ack_n <= (state == RST) ? pio_subsystem_warm_rst_n : 1'b1;

      if ((state == RST) && (nxt == RST)) begin
        if (hold < HOLD_W'(RST_HOLD))
          hold <= hold + HOLD_W'(1);
      end else begin
        hold <= '0;
      end

      outstd <= enter_rst ? '0 : sat_outstd(outstd_net);
      if (outstd_net > OUTSTD_MAX)
        outstd_ovf_o <= 1'b1;

      if ((state == DRAIN) && (nxt == RDY) && (outstd != '0))
        drain_timeout_o <= 1'b1;

      if (enter_rst || ((state == WREQ) && (nxt == RUN)))
        sw_pend <= 1'b0;
      else if (sw_warmrst_req)
        sw_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pio_rst_seq.sv
// Self-checking bench for pio_rst_seq: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pio_rst_seq;

  localparam int OUTSTD_W      = 8;
  localparam int DRAIN_TIMEOUT = 64;
  localparam int RST_HOLD      = 16;
  localparam int OMAX          = (1 << OUTSTD_W) - 1;
`ifdef PIO_RST_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int S_RUN = 0, S_WREQ = 1, S_DRAIN = 2, S_RDY = 3, S_RST = 4;

  logic       Clk_i = 1'b0;
  logic       Rstn_i = 1'b1;
  logic       cold_n, warm_n, rst_req, ini_rdy;
  logic       cold_ack_n, warm_ack_n, rst_rdy, wreq;
  logic       mon_read, mon_waitrequest, mon_readdatavalid;
  logic [3:0] mon_burstcount;
  logic       sw_req;
  logic       app_rst_n;
  logic [2:0] state_o;
  logic       drain_timeout_o, outstd_ovf_o;

  int n_vec, n_err;
  bit chk_en;

  pio_rst_seq #(
    .OUTSTD_W(OUTSTD_W), .DRAIN_TIMEOUT(DRAIN_TIMEOUT), .RST_HOLD(RST_HOLD)
  ) dut (
    .Clk_i                        (Clk_i),
    .Rstn_i                       (Rstn_i),
    .pio_subsystem_cold_rst_n     (cold_n),
    .pio_subsystem_warm_rst_n     (warm_n),
    .pio_subsystem_rst_req        (rst_req),
    .pio_initiate_rst_req_rdy     (ini_rdy),
    .pio_subsystem_cold_rst_ack_n (cold_ack_n),
    .pio_subsystem_warm_rst_ack_n (warm_ack_n),
    .pio_subsystem_rst_rdy        (rst_rdy),
    .pio_initiate_warmrst_req     (wreq),
    .mon_read                     (mon_read),
    .mon_waitrequest              (mon_waitrequest),
    .mon_readdatavalid            (mon_readdatavalid),
    .mon_burstcount               (mon_burstcount),
    .sw_warmrst_req               (sw_req),
    .app_rst_n                    (app_rst_n),
    .state_o                      (state_o),
    .drain_timeout_o              (drain_timeout_o),
    .outstd_ovf_o                 (outstd_ovf_o)
  );

  always #5 Clk_i = ~Clk_i;

  // Behavioural model: mode, beats in flight, elapsed counters, expected outputs.
  typedef struct packed {
    int st;
    int outstd;
    int drain;
    int hold;
    bit pend, cack, wack, rdy, app, req, tmo, ovf;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = S_RST; r.outstd = 0; r.drain = 0; r.hold = 0;
    r.pend = 0; r.cack = 1; r.wack = 1; r.rdy = 0; r.app = 0;
    r.req = 0; r.tmo = 0; r.ovf = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t c, bit cold, bit warm, bit rreq, bit irdy,
                                    bit rd, bit wr, int bc, bit rdv, bit sw);
    mdl_t n = c;
    bit abort = !cold || !warm;
    int v;
    if (c.st == S_RST) begin
      if (!abort && c.hold >= RST_HOLD && c.cack && c.wack) n.st = S_RUN;
    end else if (abort) begin
      n.st = S_RST;
    end else if (c.st == S_RDY) begin
      if (!rreq) n.st = S_RUN;
    end else if (c.st == S_DRAIN) begin
      if (!rreq) n.st = S_RUN;
      else if (c.outstd == 0) n.st = S_RDY;
      else if (TMO_EN && (c.drain + 1 >= DRAIN_TIMEOUT)) begin
        n.st = S_RDY;
        n.tmo = 1;
      end
    end else if (rreq) begin
      n.st = S_DRAIN;
    end else if (c.st == S_WREQ) begin
      if (irdy) n.st = S_RUN;
    end else if (c.pend) begin
      n.st = S_WREQ;
    end

    n.pend = c.pend | sw;
    if ((c.st == S_WREQ && n.st == S_RUN) || (c.st != S_RST && n.st == S_RST)) n.pend = 0;

    v = c.outstd + ((rd && !wr) ? ((bc == 0) ? 1 : bc) : 0) - (rdv ? 1 : 0);
    if (v < 0) v = 0;
    if (v > OMAX) begin
      v = OMAX;
      n.ovf = 1;
    end
    if (c.st != S_RST && n.st == S_RST) v = 0;
    n.outstd = v;

    n.drain = (c.st == S_DRAIN && n.st == S_DRAIN) ? c.drain + 1 : 0;
    n.hold  = (c.st == S_RST && n.st == S_RST) ?
              ((c.hold + 1 > RST_HOLD) ? RST_HOLD : c.hold + 1) : 0;
    n.cack  = (c.st == S_RST) ? cold : 1'b1;
    n.wack  = (c.st == S_RST) ? warm : 1'b1;
    n.rdy   = (n.st == S_RDY) || (n.st == S_RST);
    n.app   = (n.st != S_RST);
    n.req   = (n.st == S_WREQ);
    return n;
  endfunction

  mdl_t m;

  always @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i)
      m <= mdl_reset();
    else
      m <= mdl_step(m, cold_n, warm_n, rst_req, ini_rdy, mon_read, mon_waitrequest,
                    int'(mon_burstcount), mon_readdatavalid, sw_req);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk_i) begin
    if (chk_en) begin
      chk("state_o",      int'(state_o),         m.st);
      chk("rst_rdy",      int'(rst_rdy),         int'(m.rdy));
      chk("app_rst_n",    int'(app_rst_n),       int'(m.app));
      chk("warmrst_req",  int'(wreq),            int'(m.req));
      chk("cold_ack_n",   int'(cold_ack_n),      int'(m.cack));
      chk("warm_ack_n",   int'(warm_ack_n),      int'(m.wack));
      chk("drain_tmo",    int'(drain_timeout_o), int'(m.tmo));
      chk("outstd_ovf",   int'(outstd_ovf_o),    int'(m.ovf));
    end
  end

  task automatic tick();
    @(negedge Clk_i);
  endtask

  task automatic idle();
    cold_n = 1; warm_n = 1; rst_req = 0; ini_rdy = 0;
    mon_read = 0; mon_waitrequest = 0; mon_readdatavalid = 0;
    mon_burstcount = 4'd0; sw_req = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, low_cnt, hi_cnt, dcnt, guard;
    bit rdy_first;
    n_vec = 0; n_err = 0; chk_en = 0;
    idle();
    #1 Rstn_i = 1'b0;
    repeat (3) tick();
    chk_en = 1;
    tick();
    chk("reset_app",   int'(app_rst_n),  0);
    chk("reset_rdy",   int'(rst_rdy),    0);
    chk("reset_cack",  int'(cold_ack_n), 1);
    chk("reset_wack",  int'(warm_ack_n), 1);
    chk("reset_wreq",  int'(wreq),       0);
    chk("reset_state", int'(state_o),    4);

    // Release: app_rst_n rises on edge RST_HOLD+1.
    Rstn_i = 1'b1;
    edges = 0; rdy_first = 0;
    while (!app_rst_n && edges < 40) begin
      tick();
      edges++;
      if (edges == 1) rdy_first = rst_rdy;
    end
    chk("rdy_first_edge", int'(rdy_first), 1);
    chk("app_rise_edge",  edges, 17);
    chk("run_after_rel",  int'(state_o), 0);

    // Burst-4 read, then drain with four returned beats.
    mon_read = 1; mon_burstcount = 4'd4; tick();
    mon_read = 0; mon_burstcount = 4'd0;
    rst_req = 1; tick();
    chk("drain_entered", int'(state_o), 2);
    mon_readdatavalid = 1; repeat (4) tick(); mon_readdatavalid = 0;
    chk("rdy_1_after_last", int'(rst_rdy), 0);
    tick();
    chk("rdy_2_after_last", int'(rst_rdy), 1);

    // Warm reset in RDY for three cycles.
    warm_n = 0; rst_req = 0; low_cnt = 0;
    tick(); if (!app_rst_n) low_cnt++;
    chk("warm_rst_state", int'(state_o), 4);
    chk("warm_ack_1st",   int'(warm_ack_n), 1);
    tick(); if (!app_rst_n) low_cnt++;
    chk("warm_ack_2nd",   int'(warm_ack_n), 0);
    chk("cold_ack_stays", int'(cold_ack_n), 1);
    tick(); if (!app_rst_n) low_cnt++;
    warm_n = 1;
    guard = 0;
    while (!app_rst_n && guard < 60) begin
      tick(); guard++;
      if (!app_rst_n) low_cnt++;
    end
    chk("app_low_ge16",  int'(low_cnt >= 16), 1);
    chk("app_back_high", int'(app_rst_n), 1);

    // Software warm-reset request, PIO ready 5 cycles after request rises.
    sw_req = 1; tick(); sw_req = 0;
    guard = 0;
    while (!wreq && guard < 10) begin tick(); guard++; end
    chk("wreq_seen", int'(wreq), 1);
    hi_cnt = 1;
    repeat (5) begin tick(); if (wreq) hi_cnt++; end
    ini_rdy = 1; tick(); ini_rdy = 0;
    chk("wreq_high_cycles", hi_cnt, 6);
    chk("wreq_dropped",     int'(wreq), 0);
    chk("wreq_back_run",    int'(state_o), 0);

    // Burst-8 read never returned, then drain.
    mon_read = 1; mon_burstcount = 4'd8; tick();
    mon_read = 0; mon_burstcount = 4'd0;
    rst_req = 1; tick();
    dcnt = 0;
    while (state_o == 3'd2 && dcnt < 200) begin dcnt++; tick(); end
`ifdef PIO_RST_SEQ_TIMEOUT_EN
    chk("drain_cycles",  dcnt, 64);
    chk("tmo_rdy",       int'(rst_rdy), 1);
    chk("tmo_flag",      int'(drain_timeout_o), 1);
`else
    chk("drain_waits",   int'(state_o), 2);
    chk("no_tmo_flag",   int'(drain_timeout_o), 0);
`endif
    rst_req = 0; tick();
    chk("drain_abandon", int'(state_o), 0);

    // Cold reset in RUN clears the outstanding count.
    cold_n = 0; tick();
    chk("cold_rst_state", int'(state_o), 4);
    chk("cold_ack_1st",   int'(cold_ack_n), 1);
    tick();
    chk("cold_ack_2nd",   int'(cold_ack_n), 0);
    chk("warm_ack_stays", int'(warm_ack_n), 1);
    cold_n = 1;
    guard = 0;
    while (state_o != 3'd0 && guard < 60) begin tick(); guard++; end
    chk("cold_exit_run", int'(state_o), 0);
    rst_req = 1; tick();
    chk("cleared_drain", int'(state_o), 2);
    tick();
    chk("cleared_rdy",   int'(rst_rdy), 1);
    rst_req = 0; tick();

    // Saturate the outstanding counter.
    chk("ovf_clear", int'(outstd_ovf_o), 0);
    mon_read = 1; mon_burstcount = 4'd15; repeat (20) tick();
    mon_read = 0; mon_burstcount = 4'd0;
    tick();
    chk("ovf_set", int'(outstd_ovf_o), 1);
    cold_n = 0; tick(); cold_n = 1;

    // Randomized traffic and handshakes.
    for (int i = 0; i < 3000; i++) begin
      mon_read          = ($urandom_range(99) < 8);
      mon_waitrequest   = ($urandom_range(99) < 30);
      mon_burstcount    = 4'($urandom_range(15));
      mon_readdatavalid = ($urandom_range(99) < 50);
      sw_req            = ($urandom_range(99) < 3);
      ini_rdy           = ($urandom_range(99) < 25);
      if ($urandom_range(99) < 4) rst_req = !rst_req;
      cold_n            = ($urandom_range(249) != 0);
      warm_n            = ($urandom_range(249) != 0);
      tick();
    end
    idle();
    tick();

    // Mid-run Rstn_i clears sticky flags.
    #1 Rstn_i = 1'b0;
    tick();
    chk("rerst_ovf",   int'(outstd_ovf_o), 0);
    chk("rerst_tmo",   int'(drain_timeout_o), 0);
    chk("rerst_app",   int'(app_rst_n), 0);
    chk("rerst_state", int'(state_o), 4);
    Rstn_i = 1'b1;
    guard = 0;
    while (!app_rst_n && guard < 40) begin tick(); guard++; end
    chk("rerst_app_up", int'(app_rst_n), 1);
    repeat (3) tick();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pio_rst_seq.md
# pio_rst_seq

Reset-handshake sequencer for the PCIe PIO subsystem: answers the PIO's subsystem reset request only after the Avalon-MM PIO master has drained outstanding reads, acknowledges cold/warm resets, and generates a held application reset. Sits between the PIO IP's reset-handshake ports and the application slaves on the `pio_master` interface, monitoring that interface passively. Also converts a software warm-reset pulse into the PIO's `initiate_warmrst_req` handshake.

## Interface
- `OUTSTD_W`, 8: width of the outstanding-read-beat counter.
- `DRAIN_TIMEOUT`, 4096: maximum cycles spent in DRAIN before forcing ready; must be ≥1.
- `RST_HOLD`, 16: minimum cycles `app_rst_n` stays low; must be ≥1.
- `Clk_i` in 1: PIO master clock; all logic is in this domain.
- `Rstn_i` in 1: asynchronous active-low reset.
- `pio_subsystem_cold_rst_n` in 1: cold reset from the PIO, active-low.
- `pio_subsystem_warm_rst_n` in 1: warm reset from the PIO, active-low.
- `pio_subsystem_rst_req` in 1: PIO requests subsystem reset readiness.
- `pio_initiate_rst_req_rdy` in 1: PIO accepts the warm-reset initiation.
- `pio_subsystem_cold_rst_ack_n` out 1: cold reset acknowledge, active-low.
- `pio_subsystem_warm_rst_ack_n` out 1: warm reset acknowledge, active-low.
- `pio_subsystem_rst_rdy` out 1: subsystem is quiesced and ready for reset.
- `pio_initiate_warmrst_req` out 1: request that the PIO start a warm reset.
- `mon_read`, `mon_waitrequest`, `mon_readdatavalid` in 1 each: monitor taps of `pio_master`.
- `mon_burstcount` in 4: monitor tap of `pio_master` burstcount.
- `sw_warmrst_req` in 1: single-cycle software warm-reset pulse.
- `app_rst_n` out 1: application reset, active-low.
- `state_o` out 3: current FSM state encoding.
- `drain_timeout_o` out 1: sticky; a drain ended by timeout.
- `outstd_ovf_o` out 1: sticky; the outstanding counter saturated.

## Operation
- States, with `state_o` encoding: RUN=0, WREQ=1, DRAIN=2, RDY=3, RST=4.
- Outstanding counter:
  - A read is accepted when `mon_read & !mon_waitrequest`; it adds `mon_burstcount`, with 0 treated as 1.
  - Each `mon_readdatavalid` subtracts 1; on a simultaneous accept and valid the counter changes by the net amount.
  - The counter saturates at all-ones and sets `outstd_ovf_o`; it never underflows below 0.
  - The counter clears on entry to RST.
- RUN:
  - `cold_rst_n` or `warm_rst_n` low → RST. This is the abort path and takes priority.
  - Else `rst_req`=1 → DRAIN.
  - Else a pending software request → WREQ.
- `sw_warmrst_req` is latched into a pending flag. The flag clears when WREQ completes or when RST is entered. Extra pulses while the flag is set are ignored.
- WREQ:
  - `pio_initiate_warmrst_req`=1.
  - On a sampled `pio_initiate_rst_req_rdy`=1 → RUN; the request drops the next cycle.
  - Reset-low or `rst_req` inputs take priority, using the same transitions as RUN.
- DRAIN:
  - Counter==0 → RDY.
  - Timeout counter reaches `DRAIN_TIMEOUT` → RDY and set `drain_timeout_o`.
  - `rst_req` dropping → RUN.
  - Reset low → RST.
- RDY:
  - `pio_subsystem_rst_rdy`=1.
  - `cold_rst_n` or `warm_rst_n` low → RST.
  - `rst_req`=0 → RUN.
- RST:
  - `app_rst_n`=0 and `rst_rdy`=1.
  - Each `ack_n` equals its own `rst_n` registered once. Both may be low at the same time.
  - The hold counter counts from 0. Exit → RUN when both `rst_n` are high, the hold counter ≥ `RST_HOLD`, and both `ack_n` are already high.
  - On exit: `app_rst_n`=1 and the hold counter clears.
  - A reset reasserting during the hold does not restart the hold count, but RST does not exit while it is low.
- Outside RST, both `ack_n`=1 and `app_rst_n`=1.
- Sticky flags clear only on `Rstn_i`.

## Timing
- `Rstn_i` low gives:
  - state RST, hold counter 0, all counters 0, flags 0;
  - `app_rst_n`=0, both `ack_n`=1, `rst_rdy`=0, `initiate_warmrst_req`=0.
- `Rstn_i` released: `rst_rdy`=1 from the first clock edge, since the FSM is in RST. `app_rst_n` rises `RST_HOLD`+1 edges after release if both PIO resets are high.
- All outputs are registered.
- `rst_req` to `rst_rdy` with counter already 0: 2 cycles (RUN→DRAIN→RDY).
- `rst_n` falling to `ack_n` falling: 2 cycles (state change, then registered ack).
- DRAIN lasts at most `DRAIN_TIMEOUT` cycles.

## Configuration
- `PIO_RST_SEQ_TIMEOUT_EN`:
  - Defined: the drain timeout counter and `drain_timeout_o` behave as above.
  - Undefined: no timeout logic; DRAIN waits for counter==0 indefinitely; `drain_timeout_o` is tied 0.

## Test plan
- Reset release with both PIO resets high, `RST_HOLD`=16 → `app_rst_n` rises on edge 17, `state_o`=0.
- Accept a read with burstcount 4, then `rst_req`=1, then 4 `readdatavalid` → `rst_rdy` rises exactly 2 cycles after the 4th valid.
- `warm_rst_n` low for 3 cycles in RDY → `warm_ack_n` low 2 cycles after the fall, `cold_ack_n` stays 1, `app_rst_n` stays low ≥16 cycles.
- `sw_warmrst_req` pulse, `pio_initiate_rst_req_rdy` asserted 5 cycles later → `initiate_warmrst_req` high for 6 cycles, then 0.
- Burstcount-8 read never returned, `rst_req`=1, macro defined, `DRAIN_TIMEOUT`=64 → `rst_rdy` after 64 DRAIN cycles and `drain_timeout_o`=1.
- `cold_rst_n` low in RUN with no `rst_req` → RST entered next cycle, counter cleared, `cold_ack_n`=0.
